deser_queue: RTL and testbench
==============================

# deser_queue

Parametrised single-clock serial-to-parallel front end with an integrated word FIFO. It is the successor of the fixed 8-bit deserializer/queue pair, generalised in word width, queue depth and bit order. It accepts one bit per rising edge of a slow `write_in` strobe, assembles words, and queues them for a consumer that pops on rising edges of `dequeue_in`.

## Interface
- `WIDTH`, 8: data bits per word (≥2).
- `DEPTH`, 8: queue capacity in words (power of two, ≥2).
- `MSB_FIRST`, 0: 0 = first received bit is bit 0; 1 = first received bit is bit WIDTH-1.
- `clock` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `data_in` in 1: serial data bit, sampled on `write_in` rising edge.
- `write_in` in 1: bit strobe; level may last many cycles, edge-detected.
- `status_out` out 1: 1 = deserializer ready to accept bits.
- `dequeue_in` in 1: pop request; level may last many cycles, edge-detected.
- `data_out` out WIDTH: head of queue; 0 when empty.
- `len_out` out $clog2(DEPTH+1): words currently queued.
- `full_out` out 1: `len_out == DEPTH`.
- `empty_out` out 1: `len_out == 0`.
- `overflow_out` out 1: one-cycle pulse, bit strobe lost.
- `parity_err_out` out 1: one-cycle pulse, word dropped on parity failure (tied 0 without macro).

## Operation
- Edge detect: registered `write_q`/`deq_q`; write event = `write_in & ~write_q`; pop event = `dequeue_in & ~deq_q`. A held level produces exactly one event.
- Deserializer FSM:
  - COLLECT: on write event, shift `data_in` into the assembly register (position per `MSB_FIRST`), increment bit counter. When counter reaches the word length (WIDTH, or WIDTH+1 with parity), go to PUSH.
  - PUSH: one cycle. If queue not full (or pop event this cycle), write word, clear counter, return to COLLECT. If full, go to HOLD.
  - HOLD: word retained, `status_out`=0. Write events ignored and each pulses `overflow_out`. On first cycle with `len_out < DEPTH`, push and return to COLLECT.
- `status_out` = 1 in COLLECT, 0 in PUSH and HOLD.
- Queue: circular buffer, read/write pointers wrap at DEPTH. Pop event when empty is ignored (no underflow, `len_out` stays 0). Push and pop in the same cycle: both performed, `len_out` unchanged; at full this is legal.
- `data_out` is first-word-fall-through: shows the head word combinationally from storage whenever not empty.

## Timing
- Reset (`reset`=0 at a rising edge): FSM→COLLECT, counter=0, pointers=0, `len_out`=0, `data_out`=0, `empty_out`=1, `full_out`=0, `status_out`=1, `overflow_out`=0, `parity_err_out`=0, edge registers=0. Reset mid-word discards partial bits; reset in HOLD discards the held word.
- Bit capture: in the cycle following the clock edge where `write_in` is first seen high.
- Push latency: final bit captured at edge N → PUSH at N+1 → `len_out`/`data_out` updated after edge N+1.
- Pop latency: pop event seen at edge M → `len_out` decremented and new head on `data_out` after edge M.
- HOLD exit: push occurs on the same edge that frees space; `status_out` returns high after that edge.

## Configuration
- `DESER_PARITY_EN` defined: word length is WIDTH+1; the last bit is an even-parity bit. In PUSH, if XOR of all WIDTH+1 bits is 1, the word is discarded (no push, no HOLD), `parity_err_out` pulses for one cycle, and FSM returns to COLLECT.
- Not defined: word length is WIDTH; no parity logic; `parity_err_out` tied 0.

## Test plan
- Reset, send 0x99 LSB-first, `write_in` high 10 cycles/low 10 cycles per bit → one cycle after 8th capture `len_out`=1, `data_out`=0x99, `empty_out`=0.
- `MSB_FIRST`=1, same bit stream → `data_out`=0x99 bit-reversed = 0x99; then stream 0x01 sequence → `data_out`=0x80.
- Push 8 words (DEPTH=8) → `full_out`=1; 9th word enters HOLD, `status_out`=0; extra strobe → `overflow_out` single pulse; one pop → 9th word pushed, `len_out` stays 8, `status_out`=1.
- `dequeue_in` held 100 cycles with 2 words queued → exactly one pop, `len_out` 2→1; pop when empty → `len_out` stays 0.
- Final bit lands so that PUSH coincides with a pop event at `len_out`=3 → `len_out` stays 3; reset (`reset`=0) after 3 bits → all outputs at reset values, next 8 bits form a clean word.
- `DESER_PARITY_EN`: 0x99 + parity 0 → queued; 0x99 + parity 1 → not queued, `parity_err_out` one-cycle pulse, `len_out` unchanged.

Source files
------------

// File: rtl/deser_queue.sv
// deser_queue: serial-to-parallel front end feeding a first-word-fall-through
// word FIFO. Bits arrive one per rising edge of write_in, words leave one per
// rising edge of dequeue_in.
// Optional feature: define DESER_PARITY_EN to append an even-parity bit to
// every word; words failing the check are dropped and flagged on parity_err_out.
module deser_queue #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out,
  output logic                       parity_err_out
);

`ifdef DESER_PARITY_EN
  localparam int WL = WIDTH + 1;
`else
  localparam int WL = WIDTH;
`endif
  localparam int CW = $clog2(WL + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {COLLECT, PUSH, HOLD} state_t;

  state_t                        state, state_nx;
  logic                          write_q, deq_q;
  logic                          wr_ev, pop_ev;
  logic [CW-1:0]                 cnt;
  logic [WIDTH-1:0]              asm_word, asm_shift;
  logic                          par_bad;
  logic                          room, push, pop;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [LW-1:0]                 len;
  logic                          overflow_q;

  // a held strobe level yields exactly one event on its rising edge
  assign wr_ev  = write_in & ~write_q;
  assign pop_ev = dequeue_in & ~deq_q;

  // space is available now, or is being freed by a pop on this very edge
  assign room = ~full_out | pop_ev;
  assign pop  = pop_ev & ~empty_out;

  // new bit slides in from the end chosen by the bit order
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign asm_shift = {asm_word[WIDTH-2:0], data_in};
    end else begin : g_lsb
      assign asm_shift = {data_in, asm_word[WIDTH-1:1]};
    end
  endgenerate

`ifdef DESER_PARITY_EN
  logic par_bit;
  logic parity_err_q;

  // even parity over data plus parity bit must come out zero
  assign par_bad        = (^asm_word) ^ par_bit;
  assign parity_err_out = parity_err_q;

  // parity bit is the final bit of the word; error flag pulses on a drop
  always_ff @(posedge clock) begin
    if (!reset) begin
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (state == COLLECT && wr_ev && cnt == CW'(WIDTH)) par_bit <= data_in;
      parity_err_q <= (state == PUSH) & par_bad;
    end
  end
`else
  assign par_bad        = 1'b0;
  assign parity_err_out = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nx;
  end

  // FSM next state: collect bits, try to push, park the word while full
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (wr_ev && cnt == CW'(WL - 1)) state_nx = PUSH;
      PUSH: begin
        if (par_bad || room) state_nx = COLLECT;
        else                 state_nx = HOLD;
      end
      HOLD:    if (room) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // FSM outputs: ready only while collecting; push from PUSH or HOLD
  always_comb begin
    status_out = (state == COLLECT);
    push       = 1'b0;
    if (state == PUSH && !par_bad && room) push = 1'b1;
    if (state == HOLD && room)             push = 1'b1;
  end

  // edge registers, bit assembly, bit counter and overflow pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_q    <= 1'b0;
      deq_q      <= 1'b0;
      cnt        <= '0;
      asm_word   <= '0;
      overflow_q <= 1'b0;
    end else begin
      write_q    <= write_in;
      deq_q      <= dequeue_in;
      overflow_q <= wr_ev & (state != COLLECT);
      if (state == COLLECT && wr_ev) begin
        cnt <= cnt + CW'(1);
        if (cnt < CW'(WIDTH)) asm_word <= asm_shift;
      end
      if (state != COLLECT && state_nx == COLLECT) cnt <= '0;
    end
  end

  // word storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= asm_word;
  end

  // pointers wrap naturally at the power-of-two depth; push+pop keeps len
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   len <= len + LW'(1);
        2'b01:   len <= len - LW'(1);
        default: len <= len;
      endcase
    end
  end

  assign len_out      = len;
  assign full_out     = (len == LW'(DEPTH));
  assign empty_out    = (len == '0);
  assign overflow_out = overflow_q;
  assign data_out     = empty_out ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_deser_queue.sv
// Bench for deser_queue: LSB-first and MSB-first instances share one bit
// stream; a scoreboard of expected words is checked by a separate monitor on
// every pop event, plus state snapshots against a queue-level model.
module tb_deser_queue;
  localparam int W = 8;
  localparam int D = 8;
`ifdef DESER_PARITY_EN
  localparam int WL = W + 1;
`else
  localparam int WL = W;
`endif

  logic clk = 1'b0, reset = 1'b0, data_in = 1'b0, write_in = 1'b0, dequeue_in = 1'b0;
  logic st0, st1, fu0, fu1, em0, em1, ov0, ov1, pe0, pe1;
  logic [W-1:0] do0, do1;
  logic [3:0] len0, len1;

  deser_queue #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) dut0 (
    .clock(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(st0), .dequeue_in(dequeue_in), .data_out(do0), .len_out(len0),
    .full_out(fu0), .empty_out(em0), .overflow_out(ov0), .parity_err_out(pe0));

  deser_queue #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut1 (
    .clock(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(st1), .dequeue_in(dequeue_in), .data_out(do1), .len_out(len1),
    .full_out(fu1), .empty_out(em1), .overflow_out(ov1), .parity_err_out(pe1));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [W-1:0] sb0[$], sb1[$];
  logic held_v = 1'b0;
  logic [W-1:0] held0, held1;
  int ovf0 = 0, ovf1 = 0, par0 = 0, par1 = 0;
  logic deq_prev = 1'b0;

  // first stream bit lands at bit WIDTH-1 in the MSB-first instance
  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    check({tag, " len0"}, 32'(len0), sb0.size());
    check({tag, " len1"}, 32'(len1), sb1.size());
    check({tag, " full0"}, 32'(fu0), 32'(sb0.size() == D));
    check({tag, " full1"}, 32'(fu1), 32'(sb1.size() == D));
    check({tag, " empty0"}, 32'(em0), 32'(sb0.size() == 0));
    check({tag, " empty1"}, 32'(em1), 32'(sb1.size() == 0));
    check({tag, " data0"}, 32'(do0), (sb0.size() > 0) ? 32'(sb0[0]) : 32'h0);
    check({tag, " data1"}, 32'(do1), (sb1.size() > 0) ? 32'(sb1[0]) : 32'h0);
    check({tag, " status0"}, 32'(st0), 32'(!held_v));
    check({tag, " status1"}, 32'(st1), 32'(!held_v));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    data_in = b; write_in = 1'b1;
    repeat (hi) step();
    write_in = 1'b0;
    repeat (lo) step();
  endtask

  // stream w LSB first (plus parity bit when enabled); bad flips the parity
  task automatic send_word(input logic [W-1:0] w, input logic bad, input int hi,
                           input int lo, input logic pop_at_push, input logic lat_chk);
    logic [W:0] s;
    s = {(^w) ^ bad, w};
    for (int i = 0; i < WL - 1; i++) send_bit(s[i], hi, lo);
    data_in = s[WL-1]; write_in = 1'b1;
    step();  // final bit captured
    if (lat_chk) begin
      check("lat len0 before push", 32'(len0), sb0.size());
      check("lat status0 in push", 32'(st0), 32'h0);
      check("lat status1 in push", 32'(st1), 32'h0);
    end
    if (pop_at_push) dequeue_in = 1'b1;
    step();  // push edge
    if (WL == W || !bad) begin
      if (sb0.size() < D) begin
        sb0.push_back(w); sb1.push_back(rev(w));
      end else begin
        held_v = 1'b1; held0 = w; held1 = rev(w);
      end
    end
    if (lat_chk) chk_state("latency");
    dequeue_in = 1'b0;
    repeat ((hi > 2) ? hi - 2 : 0) step();
    write_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic pop(input int hold);
    dequeue_in = 1'b1;
    step();
    if (held_v) begin
      sb0.push_back(held0); sb1.push_back(held1); held_v = 1'b0;
    end
    repeat (hold - 1) step();
    dequeue_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    sb0.delete(); sb1.delete(); held_v = 1'b0;
    step();
  endtask

  // tracks the pop strobe level the design last sampled
  always @(posedge clk) deq_prev <= reset ? dequeue_in : 1'b0;

  // monitor: a pop event takes effect at the next edge; head must match scoreboard
  always @(negedge clk) begin
    if (reset && dequeue_in && !deq_prev) begin
      if (sb0.size() > 0) begin
        check("pop head dut0", 32'(do0), 32'(sb0[0]));
        check("pop head dut1", 32'(do1), 32'(sb1[0]));
        void'(sb0.pop_front());
        void'(sb1.pop_front());
      end else begin
        check("pop empty data0", 32'(do0), 32'h0);
        check("pop empty data1", 32'(do1), 32'h0);
      end
    end
    if (ov0) ovf0++;
    if (ov1) ovf1++;
    if (pe0) par0++;
    if (pe1) par1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    chk_state("reset");
    check("reset ovf0", 32'(ov0), 32'h0);
    check("reset perr0", 32'(pe0), 32'h0);

    // slow strobes, latency checked around the final bit
    send_word(8'h99, 1'b0, 10, 10, 1'b0, 1'b1);
    send_word(8'h01, 1'b0, 10, 10, 1'b0, 1'b0);
    chk_state("two words");
    pop(1);
    chk_state("head 0x01");
    pop(1);
    chk_state("drained");

    // held pop level gives one pop; pop when empty is ignored
    send_word(W'($urandom), 1'b0, 2, 2, 1'b0, 1'b0);
    send_word(W'($urandom), 1'b0, 1, 3, 1'b0, 1'b0);
    pop(100);
    chk_state("held pop");
    pop(1);
    pop(3);
    chk_state("empty pop");

    // fill, overflow into HOLD, exit by one pop
    for (int i = 0; i < D; i++) send_word(W'($urandom), 1'b0, 1, 1, 1'b0, 1'b0);
    chk_state("full");
    ovf0 = 0; ovf1 = 0;
    send_word(W'($urandom), 1'b0, 1, 2, 1'b0, 1'b0);
    chk_state("hold");
    send_bit(1'b1, 1, 2);
    check("overflow pulses dut0", 32'(ovf0), 32'h1);
    check("overflow pulses dut1", 32'(ovf1), 32'h1);
    chk_state("hold after strobe");
    pop(1);
    chk_state("hold exit");

    // reset while a word is held discards it
    send_word(W'($urandom), 1'b0, 1, 2, 1'b0, 1'b0);
    chk_state("hold again");
    do_reset();
    chk_state("reset in hold");

    // push coincides with a pop at len 3
    for (int i = 0; i < 3; i++) send_word(W'($urandom), 1'b0, 2, 1, 1'b0, 1'b0);
    send_word(W'($urandom), 1'b0, 2, 2, 1'b1, 1'b0);
    chk_state("push with pop");

    // reset after 3 bits, then a clean word
    for (int i = 0; i < 3; i++) send_bit(1'b1, 2, 2);
    do_reset();
    chk_state("reset mid word");
    send_word(8'hA5, 1'b0, 2, 2, 1'b0, 1'b0);
    chk_state("clean word");
    pop(1);

`ifdef DESER_PARITY_EN
    par0 = 0; par1 = 0;
    send_word(8'h99, 1'b0, 2, 2, 1'b0, 1'b0);
    send_word(8'h99, 1'b1, 2, 2, 1'b0, 1'b0);
    check("parity pulses dut0", 32'(par0), 32'h1);
    check("parity pulses dut1", 32'(par1), 32'h1);
    chk_state("parity drop");
`endif

    // randomized mix of words and pops
    for (int it = 0; it < 60; it++) begin
      if (held_v || (sb0.size() > 0 && $urandom_range(0, 2) == 0)) begin
        pop($urandom_range(1, 3));
      end else begin
        bad = 1'b0;
`ifdef DESER_PARITY_EN
        bad = ($urandom_range(0, 3) == 0);
`endif
        send_word(W'($urandom), bad, $urandom_range(1, 3), $urandom_range(1, 3),
                  1'($urandom_range(0, 1)), 1'b0);
      end
      chk_state("random");
    end

    while (sb0.size() > 0 || held_v) pop(1);
    chk_state("final drain");
`ifndef DESER_PARITY_EN
    check("parity tied low dut0", 32'(par0), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
